// File: rtl/rram_cfg_programmer.sv
// rram_cfg_programmer: serial write driver for a chain of 2-RRAM configuration
// cells. One configuration word is accepted per handshake. Each cell is then
// programmed in two timed pulses, cell 0 first: phase A writes r0 and phase B
// writes r1. An all-idle gap follows every pulse.
//
// Handshake: a word transfers on a rising edge where cfg_valid and cfg_ready
// are both high. cfg_ready is high only while the block is IDLE. cfg_valid
// seen in any other state is ignored, and cfg_data is sampled only on the
// transfer edge.
module rram_cfg_programmer #(
  parameter int NUM_CELLS    = 8,
  parameter int PULSE_CYCLES = 4,
  parameter int GAP_CYCLES   = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [NUM_CELLS-1:0]   cfg_data,
  output logic                   busy,
  output logic                   done,
  output logic [3*NUM_CELLS-1:0] bl,
  output logic [3*NUM_CELLS-1:0] wl,
  output logic [1:0]             dbg_state
);

  localparam int MAX_PG = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int CNT_W  = (MAX_PG > 1) ? $clog2(MAX_PG) : 1;
  localparam int CELL_W = (NUM_CELLS > 1) ? $clog2(NUM_CELLS) : 1;

  localparam logic [CNT_W-1:0]  PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CELL_W-1:0] CELL_LAST  = CELL_W'(NUM_CELLS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PULSE = 2'd1,
    S_GAP   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CELL_W-1:0]      cell_q, cell_d;
  logic                   phase_q, phase_d;   // 0 = phase A (r0), 1 = phase B (r1)
  logic [NUM_CELLS-1:0]   data_q, data_d;

  logic                   ready_d, busy_d, done_d;
  logic [2:0]             lane_bl, lane_wl;
  logic [3*NUM_CELLS-1:0] bl_d, wl_d;

  assign dbg_state = state_q;

  // Next-state logic: sequence cells and phases, and time pulses and gaps.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cell_d  = cell_q;
    phase_d = phase_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE: begin
        if (cfg_valid && cfg_ready) begin
          data_d  = cfg_data;
          cell_d  = '0;
          phase_d = 1'b0;
          cnt_d   = '0;
          state_d = S_PULSE;
        end
      end
      S_PULSE: begin
        if (cnt_q == PULSE_LAST) begin
          cnt_d   = '0;
          state_d = S_GAP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          if (!phase_q) begin
            phase_d = 1'b1;
            state_d = S_PULSE;
          end else if (cell_q == CELL_LAST) begin
            state_d = S_DONE;
          end else begin
            cell_d  = cell_q + CELL_W'(1);
            phase_d = 1'b0;
            state_d = S_PULSE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Lane choice for the cell about to be pulsed. The pair written depends on
  // the target bit, so that dout = r0 | ~r1 ends up equal to that bit.
  always_comb begin
    lane_bl = 3'b000;
    lane_wl = 3'b000;
    case ({data_d[cell_d], phase_d})
      2'b10:   begin lane_bl = 3'b100; lane_wl = 3'b001; end  // r0 -> 1
      2'b11:   begin lane_bl = 3'b010; lane_wl = 3'b100; end  // r1 -> 0
      2'b00:   begin lane_bl = 3'b001; lane_wl = 3'b100; end  // r0 -> 0
      default: begin lane_bl = 3'b100; lane_wl = 3'b010; end  // r1 -> 1
    endcase
  end

  // Registered outputs are computed from the next state. This makes a pulse
  // appear in the cycle right after the edge that enters PULSE.
  always_comb begin
    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
    bl_d    = '0;
    wl_d    = '0;
    if (state_d == S_PULSE) begin
      for (int i = 0; i < NUM_CELLS; i++) begin
        if (CELL_W'(i) == cell_d) begin
          bl_d[3*i +: 3] = lane_bl;
          wl_d[3*i +: 3] = lane_wl;
        end
      end
    end
  end

  // State and output registers. Reset clears the lines immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      cell_q    <= '0;
      phase_q   <= 1'b0;
      data_q    <= '0;
      cfg_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      bl        <= '0;
      wl        <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cell_q    <= cell_d;
      phase_q   <= phase_d;
      data_q    <= data_d;
      cfg_ready <= ready_d;
      busy      <= busy_d;
      done      <= done_d;
      bl        <= bl_d;
      wl        <= wl_d;
    end
  end

endmodule

// File: tb/tb_rram_cfg_programmer.sv
// Bench for rram_cfg_programmer. It drives a small instance (4 cells, short
// pulses) and a default-size instance with an attached behavioural RRAM array.
// A per-cycle expected trace of {ready, busy, done, bl, wl} is queued when each
// word is accepted, then popped and compared on every falling edge.
module tb_rram_cfg_programmer;

  localparam int EW = 51;  // {ready, busy, done, bl[23:0], wl[23:0]}

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        v8 = 1'b0, ready8, busy8, done8;
  logic [7:0]  d8 = '0;
  logic [23:0] bl8, wl8;
  logic [1:0]  st8;

  logic        v4 = 1'b0, ready4, busy4, done4;
  logic [3:0]  d4 = '0;
  logic [11:0] bl4, wl4;
  logic [1:0]  st4;

  rram_cfg_programmer dut8 (
    .clk(clk), .rst(rst), .cfg_valid(v8), .cfg_ready(ready8), .cfg_data(d8),
    .busy(busy8), .done(done8), .bl(bl8), .wl(wl8), .dbg_state(st8)
  );

  rram_cfg_programmer #(.NUM_CELLS(4), .PULSE_CYCLES(2), .GAP_CYCLES(1)) dut4 (
    .clk(clk), .rst(rst), .cfg_valid(v4), .cfg_ready(ready4), .cfg_data(d4),
    .busy(busy4), .done(done4), .bl(bl4), .wl(wl4), .dbg_state(st4)
  );

  logic [EW-1:0] exp8_q[$];
  logic [EW-1:0] exp4_q[$];
  logic [7:0]    word_q[$];
  int  n_checks = 0;
  int  n_pass   = 0;
  bit  mon8_en  = 1'b0;
  bit  mon4_en  = 1'b0;

  // Behavioural 2-RRAM cells attached to the 8-cell instance.
  logic [7:0] r0 = '0;
  logic [7:0] r1 = '0;
  wire  [7:0] dout = r0 | ~r1;

  always @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (bl8[3*i+2] && wl8[3*i])   r0[i] <= 1'b1;
      if (bl8[3*i]   && wl8[3*i+2]) r0[i] <= 1'b0;
      if (bl8[3*i+1] && wl8[3*i+2]) r1[i] <= 1'b0;
      if (bl8[3*i+2] && wl8[3*i+1]) r1[i] <= 1'b1;
    end
  end

  task automatic check(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Returns {bl[2:0], wl[2:0]} for one cell and phase.
  function automatic logic [5:0] lanes(input logic b, input logic ph);
    case ({b, ph})
      2'b10:   return {3'b100, 3'b001};
      2'b11:   return {3'b010, 3'b100};
      2'b00:   return {3'b001, 3'b100};
      default: return {3'b100, 3'b010};
    endcase
  endfunction

  task automatic push_e(input bit sel, input logic [EW-1:0] e);
    if (sel) exp8_q.push_back(e);
    else     exp4_q.push_back(e);
  endtask

  task automatic push_word(input bit sel, input int n, input int p, input int g,
                           input logic [7:0] data);
    logic [5:0]  ln;
    logic [23:0] b, w;
    for (int c = 0; c < n; c++) begin
      for (int ph = 0; ph < 2; ph++) begin
        ln = lanes(data[c], ph[0]);
        b  = 24'(ln[5:3]) << (3*c);
        w  = 24'(ln[2:0]) << (3*c);
        for (int k = 0; k < p; k++) push_e(sel, {3'b010, b, w});
        for (int k = 0; k < g; k++) push_e(sel, {3'b010, 48'b0});
      end
    end
    push_e(sel, {3'b011, 48'b0});
    if (sel) word_q.push_back(data);
  endtask

  // Called just after a rising edge. Waits (bounded) for ready, then offers a
  // word and returns just after the accepting edge with the trace queued.
  task automatic accept(input bit sel, input logic [7:0] data, input bit hold);
    int k = 0;
    while (!(sel ? ready8 : ready4) && k < 300) begin
      @(posedge clk); #1; k++;
    end
    check(sel ? "dut8_ready_wait" : "dut4_ready_wait", EW'(sel ? ready8 : ready4), EW'(1));
    if (sel) begin v8 = 1'b1; d8 = data; end
    else     begin v4 = 1'b1; d4 = data[3:0]; end
    @(posedge clk); #1;
    if (!hold) begin v8 = 1'b0; v4 = 1'b0; end
    if (sel) push_word(1'b1, 8, 4, 2, data);
    else     push_word(1'b0, 4, 2, 1, data);
  endtask

  task automatic wait_drain(input bit sel);
    int k = 0;
    while ((sel ? exp8_q.size() : exp4_q.size()) > 0 && k < 400) begin
      @(posedge clk); #1; k++;
    end
    check(sel ? "dut8_drain" : "dut4_drain",
          EW'((sel ? exp8_q.size() : exp4_q.size()) == 0), EW'(1));
  endtask

  // Scoreboard for the 8-cell instance, with one-hot and cell-content checks.
  always @(negedge clk) begin
    logic [EW-1:0] e;
    logic          ok;
    if (mon8_en) begin
      e = (exp8_q.size() > 0) ? exp8_q.pop_front() : {3'b100, 48'b0};
      check("dut8_cycle", {ready8, busy8, done8, bl8, wl8}, e);
      ok = $onehot0(bl8) && $onehot0(wl8) && ((bl8 == '0) == (wl8 == '0));
      check("dut8_onehot", EW'(ok), EW'(1));
      if (e[48] && word_q.size() > 0) check("dut8_dout", EW'(dout), EW'(word_q.pop_front()));
    end
  end

  // Scoreboard for the 4-cell instance.
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (mon4_en) begin
      e = (exp4_q.size() > 0) ? exp4_q.pop_front() : {3'b100, 48'b0};
      check("dut4_cycle", {ready4, busy4, done4, 12'b0, bl4, 12'b0, wl4}, e);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset asserted while the clock is low, released a cycle later.
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    check("rst_outputs8", EW'({bl8, wl8, busy8, done8}), EW'(0));
    check("rst_outputs4", EW'({bl4, wl4, busy4, done4}), EW'(0));
    @(negedge clk); #2;
    rst = 1'b0;
    #1;
    check("rst_ready8", EW'(ready8), EW'(1));
    check("rst_ready4", EW'(ready4), EW'(1));
    @(posedge clk); #1;
    mon8_en = 1'b1;
    mon4_en = 1'b1;

    // Small instance: 4'b0101, done expected 24 cycles after the accept.
    accept(1'b0, 8'h05, 1'b0);
    wait_drain(1'b0);

    // 8'hA5, with new data offered while busy; that data must be ignored.
    accept(1'b1, 8'hA5, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    v8 = 1'b1;
    d8 = 8'h5A;
    repeat (20) @(posedge clk);
    #1;
    v8 = 1'b0;
    wait_drain(1'b1);

    // cfg_valid held high: 8'h3C, then 8'h96 accepted in the IDLE cycle after DONE.
    accept(1'b1, 8'h3C, 1'b1);
    push_e(1'b1, {3'b100, 48'b0});
    d8 = 8'h96;
    push_word(1'b1, 8, 4, 2, 8'h96);
    repeat (98) @(posedge clk);
    #1;
    v8 = 1'b0;
    wait_drain(1'b1);

    // Reset during the cell 2 phase B pulse of 8'h5A (bit 2 = 0: bl[8], wl[7]).
    accept(1'b1, 8'h5A, 1'b0);
    repeat (31) @(posedge clk);
    #1;
    mon8_en = 1'b0;
    mon4_en = 1'b0;
    exp8_q.delete();
    word_q.delete();
    check("pre_rst_pulse", EW'({bl8, wl8}), EW'({24'h000100, 24'h000080}));
    rst = 1'b1;
    #1;
    check("mid_rst_outputs", EW'({bl8, wl8, busy8, done8}), EW'(0));
    @(negedge clk); #2;
    rst = 1'b0;
    #1;
    check("mid_rst_ready", EW'({ready8, busy8, done8}), EW'(3'b100));
    @(posedge clk); #1;
    mon8_en = 1'b1;
    mon4_en = 1'b1;

    // Full reprogram after the interrupted write.
    accept(1'b1, 8'hFF, 1'b0);
    wait_drain(1'b1);
    repeat (3) @(posedge clk);
    #1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
